// File: rtl/bcd_updown_ctr_if.sv
// Control and status bundle of the BCD up/down counter; slave = counter side.
// Carries no clock; the counter's clk/rst stay plain ports.
interface bcd_updown_ctr_if #(
    parameter int DIGITS = 2
);
    localparam int W = 4 * DIGITS;

    logic         en;
    logic         up;
    logic         clr;
    logic         ld;
    logic [W-1:0] ld_val;
    logic [W-1:0] cnt;
    logic         tc;
    logic         wrap;
    logic         ld_err;

    modport slave (
        input  en, up, clr, ld, ld_val,
        output cnt, tc, wrap, ld_err
    );

    modport master (
        output en, up, clr, ld, ld_val,
        input  cnt, tc, wrap, ld_err
    );
endinterface

// File: rtl/bcd_updown_ctr.sv
// Multi-digit BCD up/down counter with sync clear/load, wrap and bad-load pulses.
// Latency: one edge for cnt/wrap/ld_err, tc combinational; no backpressure, every edge acts.
module bcd_updown_ctr #(
    parameter int DIGITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    bcd_updown_ctr_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]  cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic          ld_err_q, ld_err_d;

    logic [DIGITS:0] all9;
    logic [DIGITS:0] all0;
    logic [W-1:0]    step_val;
    logic [W-1:0]    ld_clean;
    logic            ld_bad;
    logic            term;

    always_comb begin
        all9     = '0;
        all0     = '0;
        all9[0]  = 1'b1;
        all0[0]  = 1'b1;
        step_val = cnt_q;
        ld_clean = '0;
        ld_bad   = 1'b0;

        // all9[i]/all0[i]: every digit below i is 9/0, i.e. digit i takes the carry/borrow
        for (int i = 0; i < DIGITS; i++) begin
            all9[i+1] = all9[i] & (cnt_q[4*i +: 4] == 4'd9);
            all0[i+1] = all0[i] & (cnt_q[4*i +: 4] == 4'd0);

            if (bus.up) begin
                if (all9[i]) begin
                    step_val[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd9) ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
                end
            end else if (all0[i]) begin
                step_val[4*i +: 4] = (cnt_q[4*i +: 4] == 4'd0) ? 4'd9 : cnt_q[4*i +: 4] - 4'd1;
            end

            if (bus.ld_val[4*i +: 4] > 4'd9) begin
                ld_bad = 1'b1;
            end else begin
                ld_clean[4*i +: 4] = bus.ld_val[4*i +: 4];
            end
        end

        term = bus.en & (bus.up ? all9[DIGITS] : all0[DIGITS]);

        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        ld_err_d = 1'b0;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (bus.ld) begin
            cnt_d    = ld_clean;
            ld_err_d = ld_bad;
        end else if (bus.en) begin
            cnt_d  = step_val;
            wrap_d = term;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign bus.cnt    = cnt_q;
    assign bus.tc     = term;
    assign bus.wrap   = wrap_q;
    assign bus.ld_err = ld_err_q;
endmodule

// File: tb/tb_bcd_updown_ctr.sv
// Randomised scoreboard bench for bcd_updown_ctr; the reference model counts in plain integers.
module tb_bcd_updown_ctr;
    localparam int D = 2;
    localparam int W = 4 * D;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcd_updown_ctr_if #(.DIGITS(D)) bus ();
    bcd_updown_ctr #(.DIGITS(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         wrap;
        logic         err;
    } exp_t;

    exp_t sq[$];
    logic tq[$];

    int   tests = 0;
    int   fails = 0;
    int   maxv;
    int   m_val;
    logic m_wrap;
    logic m_err;

    function automatic logic [W-1:0] to_bcd(int v);
        logic [W-1:0] b;
        int p;
        b = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            b[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return b;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step(logic r, logic e, logic u, logic c, logic l, logic [W-1:0] v, bit arst = 1'b0);
        @(negedge clk);
        rst        = r;
        bus.en     = e;
        bus.up     = u;
        bus.clr    = c;
        bus.ld     = l;
        bus.ld_val = v;
        tq.push_back(e && ((u && m_val == maxv) || (!u && m_val == 0)));
        if (arst) begin
            #3 rst = 1'b0;
            #1;
            chk("async_rst_cnt", 32'(bus.cnt), 32'h0);
            chk("async_rst_wrap", 32'(bus.wrap), 32'h0);
            chk("async_rst_ld_err", 32'(bus.ld_err), 32'h0);
        end
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (!rst || c) begin
            m_val = 0;
        end else if (l) begin
            int p;
            m_val = 0;
            p = 1;
            for (int i = 0; i < D; i++) begin
                int d;
                d = int'(v[4*i +: 4]);
                if (d > 9) m_err = 1'b1;
                else m_val = m_val + d * p;
                p = p * 10;
            end
        end else if (e) begin
            if (u) begin
                m_wrap = (m_val == maxv);
                m_val  = (m_val + 1) % (maxv + 1);
            end else begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + maxv) % (maxv + 1);
            end
        end
        sq.push_back({to_bcd(m_val), m_wrap, m_err});
    endtask

    // State monitor: registered outputs just after each edge
    initial begin
        forever begin
            exp_t x;
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                x = sq.pop_front();
                chk("cnt", 32'(bus.cnt), 32'(x.cnt));
                chk("wrap", 32'(bus.wrap), 32'(x.wrap));
                chk("ld_err", 32'(bus.ld_err), 32'(x.err));
            end
        end
    end

    // tc monitor: combinational output once inputs have settled mid-cycle
    initial begin
        forever begin
            logic t;
            @(negedge clk);
            #2;
            if (tq.size() > 0) begin
                t = tq.pop_front();
                chk("tc", 32'(bus.tc), 32'(t));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en = 1'b0; bus.up = 1'b0; bus.clr = 1'b0; bus.ld = 1'b0; bus.ld_val = '0;
        maxv = 1;
        for (int i = 0; i < D; i++) maxv = maxv * 10;
        maxv = maxv - 1;
        m_val = 0; m_wrap = 1'b0; m_err = 1'b0;

        for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);

        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h97);
        for (int i = 0; i < 4; i++)  step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h23);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA7);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFC);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 300; i++) begin
            step(1'b1, ($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 20) == 0,
                 ($urandom % 8) == 0, W'($urandom));
        end

        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h60);
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);

        @(negedge clk);
        @(negedge clk);
        #3;
        chk("drain_state_q", sq.size(), 0);
        chk("drain_tc_q", tq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
